rd_port_arbiter: RTL and testbench
==================================

# rd_port_arbiter

Round-robin arbiter and sequencer that shares one `mux2048to1_n` read port among `N_REQ` requesters. It sits between the requesters, which use a valid/ready address channel, and the shared mux. The block drives the mux select from a register, samples the mux output one cycle later, and returns the word on a single tagged response channel with backpressure. There is one read in flight at a time.

## Interface
Parameters:
- `n`, 32: data word width; must match the shared mux `n`.
- `ADDR`, 11: select width; the shared mux has 2**ADDR entries.
- `N_REQ`, 4: number of requesters, 2..8.
- `IDW`, 2: requester-id width, equal to clog2(N_REQ).

Ports:
- `clk_i`  in  1: clock, rising edge.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `req_valid_i`  in  N_REQ: per-requester request valid.
- `req_addr_i`  in  N_REQ x ADDR: per-requester read address, unpacked `[0:N_REQ-1]`.
- `req_ready_o`  out  N_REQ: one-hot grant/accept; a request transfers when valid and ready are both high.
- `mux_sel_o`  out  ADDR: registered select to the shared mux `sel`.
- `mux_data_i`  in  n: shared mux `data_o`; combinational function of `mux_sel_o`.
- `rsp_valid_o`  out  1: response valid.
- `rsp_id_o`  out  IDW: index of the requester that owns the response.
- `rsp_data_o`  out  n: read data.
- `rsp_ready_i`  in  1: response accepted by the owner named in `rsp_id_o`.

## Operation
FSM states are IDLE, READ and RESP.

**IDLE**
- If any `req_valid_i` is set, pick a winner `w` by round-robin starting at pointer `ptr`.
- Assert `req_ready_o[w]` combinationally in the same cycle.
- On the clock edge:
  - `mux_sel_o <= req_addr_i[w]`
  - `rsp_id_o <= w`
  - `ptr <= (w+1) mod N_REQ`
  - go to READ.
- If no request is valid, stay in IDLE with all `req_ready_o` at 0.

**READ**
- `req_ready_o` is all 0.
- On the clock edge: `rsp_data_o <= mux_data_i`, then go to RESP.

**RESP**
- `rsp_valid_o=1`; `rsp_id_o` and `rsp_data_o` are held stable.
- If `rsp_ready_i=0`, stay in RESP with `req_ready_o` all 0 (backpressure).
- If `rsp_ready_i=1` and any request is valid, perform the IDLE arbitration in this same cycle and go directly to READ (back-to-back).
- If `rsp_ready_i=1` and no request is valid, go to IDLE.

**Arbitration rules**
- Round-robin: the winner is the first set `req_valid_i[(ptr+k) mod N_REQ]` for k = 0..N_REQ-1.
- `ptr` advances only on a grant.
- A requester that drops `req_valid_i` before it is granted loses nothing; there is no request storage.
- `req_ready_o` is never asserted to a requester whose valid is low.

## Timing
Reset values (asserted asynchronously by `rst_ni=0`):
- State is IDLE.
- `ptr=0`, `mux_sel_o=0`, `rsp_id_o=0`, `rsp_data_o=0`.
- `rsp_valid_o=0`, `req_ready_o=0`.

Latency and throughput:
- Accept in cycle T gives `rsp_valid_o` high from cycle T+2.
- Sustained throughput is one read per 2 cycles when `rsp_ready_i` is held high.

Constraints and boundary conditions:
- `mux_sel_o` changes only on an accept edge. It holds its value in READ and RESP, and in IDLE after a read.
- The shared mux path must settle within one cycle, from `mux_sel_o` register output to `mux_data_i` sampled at the READ edge.
- Simultaneous response handshake and new request in RESP: both complete in the same cycle, and the new winner is computed with the already-updated round-robin order.
- All requesters valid at once: grants follow `ptr` order 0,1,2,3,0... from reset.
- Reset mid-operation, in READ or RESP: the pending response is discarded, `rsp_valid_o` drops immediately, and nothing is re-issued after reset.
- `ptr` wraps from N_REQ-1 to 0.

## Configuration
- `RD_ARB_FIXED_PRIO_EN` defined: fixed priority, with the lowest set index winning. `ptr` is not implemented and grants ignore history. All other behaviour is unchanged.
- Not defined: round-robin as described in Operation.

## Test plan
- **Single request.** After reset, `req_valid_i=4'b0100`, `req_addr_i[2]=11'h7FF`, mux entry 0x7FF=0xDEADBEEF, `rsp_ready_i=1`.
  - `req_ready_o=4'b0100` in cycle 0.
  - `mux_sel_o=0x7FF` in cycle 1.
  - `rsp_valid_o=1`, `rsp_id_o=2`, `rsp_data_o=0xDEADBEEF` in cycle 2.
- **Round-robin fairness.** All four valid continuously, `rsp_ready_i=1`, addresses 0x001..0x004.
  - Grant order is 0,1,2,3,0, one grant every 2 cycles.
  - Each response carries the matching id and data.
  - With `RD_ARB_FIXED_PRIO_EN`, the grants are 0,0,0,0.
- **Backpressure.** Hold `rsp_ready_i=0` for 5 cycles during RESP while requester 1 is valid.
  - `rsp_valid_o`, `rsp_id_o` and `rsp_data_o` stay stable.
  - `req_ready_o=0`.
  - `mux_sel_o` is unchanged.
  - Requester 1 is granted in the cycle `rsp_ready_i` rises.
- **Idle gap.** A single request with `rsp_ready_i=1` and no further requests.
  - After the response handshake, the FSM returns to IDLE and `rsp_valid_o=0`.
  - A later request is accepted the same cycle it is asserted.
- **Reset mid-read.**
  - `rst_ni` pulsed low during READ: `rsp_valid_o` is never asserted for that request, all outputs return to their reset values asynchronously, and `ptr=0`.
  - `rst_ni` pulsed low during RESP: `rsp_valid_o` drops immediately.
- **Address boundaries.**
  - Address 0x000 returns mux entry 0.
  - Address 0x400 returns entry 1024, selecting the upper 1024-entry half.
  - Address 0x3FF returns entry 1023.

Source files
------------

// File: rtl/rd_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered-select read port among N_REQ requesters.
// Optional macro RD_ARB_FIXED_PRIO_EN: fixed priority (lowest set index wins), no rotating pointer.
`timescale 1ns/1ps
module rd_port_arbiter #(
    parameter int n     = 32,
    parameter int ADDR  = 11,
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  logic [ADDR-1:0]        req_addr_i [0:N_REQ-1],
    output logic [N_REQ-1:0]       req_ready_o,
    output logic [ADDR-1:0]        mux_sel_o,
    input  logic [n-1:0]           mux_data_i,
    output logic                   rsp_valid_o,
    output logic [IDW-1:0]         rsp_id_o,
    output logic [n-1:0]           rsp_data_o,
    input  logic                   rsp_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR-1:0]    r_sel;
    logic [IDW-1:0]     r_id;
    logic [n-1:0]       r_data;
    logic               r_valid;
    logic [IDW-1:0]     w_win;
    logic               w_any;
    logic               w_grant;
`ifndef RD_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]     r_ptr;
`endif

    assign w_any = |req_valid_i;
    // Grants are gated by reset so req_ready_o reads 0 while rst_ni is low.
    assign w_grant = rst_ni & w_any &
                     ((r_state == S_IDLE) | ((r_state == S_RESP) & rsp_ready_i));
    assign req_ready_o = {{(N_REQ-1){1'b0}}, w_grant} << w_win;

    // Winner search: scan from the lowest priority upward so the highest-priority hit is the last write.
    always_comb begin
        logic [IDW:0] w_sum;
        w_win = '0;
        w_sum = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
`ifdef RD_ARB_FIXED_PRIO_EN
            w_sum = (IDW+1)'(k);
`else
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            w_sum = (w_sum >= (IDW+1)'(N_REQ)) ? (w_sum - (IDW+1)'(N_REQ)) : w_sum;
`endif
            w_win = req_valid_i[w_sum[IDW-1:0]] ? w_sum[IDW-1:0] : w_win;
        end
    end

    // Next-state logic; a granted request in RESP goes straight back to READ.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: w_state_nxt = w_grant ? S_READ : S_IDLE;
            S_READ: w_state_nxt = S_RESP;
            S_RESP: begin
                if (!rsp_ready_i) begin
                    w_state_nxt = S_RESP;
                end else if (w_grant) begin
                    w_state_nxt = S_READ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and response-valid flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt == S_RESP);
        end
    end

    // Select, owner id and read data; select only moves on an accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sel  <= '0;
            r_id   <= '0;
            r_data <= '0;
        end else begin
            if (w_grant) begin
                r_sel <= req_addr_i[w_win];
                r_id  <= w_win;
            end
            if (r_state == S_READ) begin
                r_data <= mux_data_i;
            end
        end
    end

`ifndef RD_ARB_FIXED_PRIO_EN
    // Round-robin pointer: one past the last winner, wrapping at N_REQ.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_win == IDW'(N_REQ - 1)) ? '0 : (w_win + IDW'(1));
        end
    end
`endif

    assign mux_sel_o   = r_sel;
    assign rsp_id_o    = r_id;
    assign rsp_data_o  = r_data;
    assign rsp_valid_o = r_valid;

endmodule

// File: tb/tb_rd_port_arbiter.sv
// Self-checking bench for rd_port_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model; honours RD_ARB_FIXED_PRIO_EN.
`timescale 1ns/1ps
module tb_rd_port_arbiter;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [10:0] req_addr [0:N-1];
    logic [3:0]  req_ready;
    logic [10:0] mux_sel;
    logic [31:0] mux_data;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_ready;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_phase;
    int          m_ptr;
    logic [10:0] m_sel;
    int          m_id;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    function automatic logic [31:0] mux_word(input logic [10:0] s);
        if (s == 11'h7FF) return 32'hDEADBEEF;
        return ({21'd0, s} * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    assign mux_data = mux_word(mux_sel);

    rd_port_arbiter #(.n(32), .ADDR(11), .N_REQ(4), .IDW(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_addr_i(req_addr),
        .req_ready_o(req_ready), .mux_sel_o(mux_sel), .mux_data_i(mux_data),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
        .rsp_ready_i(rsp_ready)
    );

    function automatic int model_winner(input logic [3:0] v);
`ifdef RD_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (v[k]) return k;
`else
        for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
        return -1;
    endfunction

    function automatic bit model_grant(input logic [3:0] v, input logic rdy);
        return (v != 4'd0) && (m_phase == 0 || (m_phase == 2 && rdy));
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_sel = 11'd0; m_id = 0; m_data = 32'd0;
    endtask

    task automatic model_step();
        int w;
        w = model_winner(req_valid);
        if (model_grant(req_valid, rsp_ready)) begin
            m_sel = req_addr[w];
            m_id  = w;
`ifndef RD_ARB_FIXED_PRIO_EN
            m_ptr = (w + 1) % N;
`endif
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_data  = mux_word(m_sel);
            m_phase = 2;
        end else if (m_phase == 2 && rsp_ready) begin
            m_phase = 0;
        end
    endtask

    task automatic apply(input logic [3:0] v, input logic rdy);
        @(negedge clk);
        req_valid = v;
        rsp_ready = rdy;
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0; req_valid = 4'd0; rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b0;
        for (int k = 0; k < N; k++) req_addr[k] = 11'(k + 1);
        #1;
        checks++; if (req_ready !== 4'd0) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
        checks++; if (mux_sel !== 11'd0) begin errors++; $display("FAIL reset_sel got %h want 000", mux_sel); end
        checks++; if (rsp_id !== 2'd0 || rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp got id %0d data %h want 0/0", rsp_id, rsp_data); end
        @(negedge clk);
        req_valid = 4'd0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        reset_dut();
        req_addr[2] = 11'h7FF;
        apply(4'b0100, 1'b1);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
        apply(4'b0000, 1'b1);
        checks++; if (mux_sel !== 11'h7FF || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_sel got %h/%b want 7ff/0", mux_sel, rsp_valid); end
        apply(4'b0000, 1'b1);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_rsp got v%b id%0d %h want v1 id2 deadbeef", rsp_valid, rsp_id, rsp_data);
        end
        req_addr[2] = 11'd3;
    endtask

    task automatic test_round_robin();
        int order [0:4];
`ifdef RD_ARB_FIXED_PRIO_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        reset_dut();
        for (int k = 0; k < N; k++) req_addr[k] = 11'(k + 1);
        for (int i = 0; i < 10; i++) begin
            apply(4'b1111, 1'b1);
            checks++;
            if (req_ready !== ((i % 2 == 0) ? (4'b0001 << order[i/2]) : 4'b0000)) begin
                errors++; $display("FAIL rr_grant cycle %0d got %b", i, req_ready);
            end
            if (i >= 2 && i % 2 == 0) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(order[i/2-1]) || rsp_data !== mux_word(11'(order[i/2-1] + 1))) begin
                    errors++; $display("FAIL rr_rsp cycle %0d got v%b id%0d %h want id%0d", i, rsp_valid, rsp_id, rsp_data, order[i/2-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        req_addr[0] = 11'h123;
        req_addr[1] = 11'h456;
        apply(4'b0001, 1'b1);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_first got %b want 0001", req_ready); end
        apply(4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            apply(4'b0010, 1'b0);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== mux_word(11'h123) || req_ready !== 4'd0 || mux_sel !== 11'h123) begin
                errors++; $display("FAIL bp_hold cycle %0d got v%b id%0d %h rdy%b sel%h", i, rsp_valid, rsp_id, rsp_data, req_ready, mux_sel);
            end
        end
        apply(4'b0010, 1'b1);
        checks++; if (req_ready !== 4'b0010 || rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_release got %b/%b want 0010/1", req_ready, rsp_valid); end
        apply(4'b0000, 1'b1);
        checks++; if (mux_sel !== 11'h456 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_next got %h/%b want 456/0", mux_sel, rsp_valid); end
    endtask

    task automatic test_idle_gap();
        reset_dut();
        req_addr[3] = 11'h055;
        apply(4'b1000, 1'b1);
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL gap_grant got %b want 1000", req_ready); end
        apply(4'b0000, 1'b1);
        apply(4'b0000, 1'b1);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin errors++; $display("FAIL gap_rsp got v%b id%0d want v1 id3", rsp_valid, rsp_id); end
        for (int i = 0; i < 3; i++) begin
            apply(4'b0000, 1'b1);
            checks++; if (rsp_valid !== 1'b0 || mux_sel !== 11'h055) begin errors++; $display("FAIL gap_idle got v%b sel%h want v0 sel055", rsp_valid, mux_sel); end
        end
        apply(4'b0001, 1'b1);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL gap_accept got %b want 0001", req_ready); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        req_addr[1] = 11'h2AA;
        req_addr[0] = 11'h011;
        apply(4'b0010, 1'b1);
        apply(4'b0000, 1'b1);
        checks++; if (mux_sel !== 11'h2AA) begin errors++; $display("FAIL midrd_sel got %h want 2aa", mux_sel); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || mux_sel !== 11'd0 || rsp_id !== 2'd0 || rsp_data !== 32'd0 || req_ready !== 4'd0) begin
            errors++; $display("FAIL midrd_async got v%b sel%h id%0d %h", rsp_valid, mux_sel, rsp_id, rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(4'b0000, 1'b1);
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrd_reissue cycle %0d got v%b want 0", i, rsp_valid); end
        end
        apply(4'b1111, 1'b1);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrd_ptr got %b want 0001", req_ready); end
        apply(4'b0000, 1'b1);
        apply(4'b0000, 1'b0);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL midrsp_pre got %b want 1", rsp_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrsp_drop got %b want 0", rsp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_addr_bounds();
        logic [10:0] addrs [0:2];
        addrs = '{11'h000, 11'h400, 11'h3FF};
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            req_addr[i] = addrs[i];
            apply(4'b0001 << i, 1'b1);
            apply(4'b0000, 1'b1);
            checks++; if (mux_sel !== addrs[i]) begin errors++; $display("FAIL bound_sel got %h want %h", mux_sel, addrs[i]); end
            apply(4'b0000, 1'b1);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== mux_word(addrs[i]) || rsp_id !== 2'(i)) begin
                errors++; $display("FAIL bound_data got v%b %h want %h", rsp_valid, rsp_data, mux_word(addrs[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_ready;
        reset_dut();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) req_addr[k] = 11'($urandom_range(0, 2047));
            req_valid = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = model_grant(req_valid, rsp_ready) ? (4'b0001 << model_winner(req_valid)) : 4'b0000;
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cycle %0d got %b want %b", c, req_ready, exp_ready); end
            checks++; if (rsp_valid !== (m_phase == 2)) begin errors++; $display("FAIL rnd_valid cycle %0d got %b want %0d", c, rsp_valid, m_phase == 2); end
            checks++; if (mux_sel !== m_sel) begin errors++; $display("FAIL rnd_sel cycle %0d got %h want %h", c, mux_sel, m_sel); end
            checks++; if (rsp_id !== 2'(m_id) || rsp_data !== m_data) begin
                errors++; $display("FAIL rnd_rsp cycle %0d got id%0d %h want id%0d %h", c, rsp_id, rsp_data, m_id, m_data);
            end
            model_step();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_idle_gap();
        test_reset_mid();
        test_addr_bounds();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
